// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for reset_sequencer.
//   rst_seq_state_e : sequencer FSM states (3-bit encoding)
//   idx_w()         : width of a stage index for a given stage count
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_DELAY     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } rst_seq_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rst_seq_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
//   clk   in  1      destination clock
//   rst_n in  1      asynchronous active-low clear (both stages clear to 0)
//   d     in  WIDTH  asynchronous inputs
//   q     out WIDTH  synchronized outputs (2 clk latency)
module rst_seq_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset-release controller. After PLL lock, releases NUM_STAGES
// active-low domain resets one at a time, each STAGE_DELAY cycles after the
// stage is entered, waiting for that domain's ack before moving on. Restarts on
// PLL loss or soft_rst_req; flags a stage whose ack never arrives.
//   clk          in   1           system clock
//   rstn_in      in   1           asynchronous active-low reset
//   pll_locked   in   1           PLL lock level
//   stage_ack    in   NUM_STAGES  per-domain ready
//   soft_rst_req in   1           one-cycle pulse, restarts the sequence
//   rstn_stage   out  NUM_STAGES  active-low domain resets (registered)
//   seq_done     out  1           all stages released and acknowledged
//   seq_err      out  1           ack timeout, held until soft_rst_req/rstn_in
//   err_stage    out  clog2(N)    stage that timed out
// Build option: define RESET_SEQUENCER_SYNC_EN to pass pll_locked and
// stage_ack through a 2-flop synchronizer (adds 2 cycles of input latency).
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned STAGE_DELAY = 256,
  parameter int unsigned ACK_TIMEOUT = 65535,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rstn_in,
  input  logic                          pll_locked,
  input  logic [NUM_STAGES-1:0]         stage_ack,
  input  logic                          soft_rst_req,
  output logic [NUM_STAGES-1:0]         rstn_stage,
  output logic                          seq_done,
  output logic                          seq_err,
  output logic [$clog2(NUM_STAGES)-1:0] err_stage
);

  localparam int unsigned IDX_W = idx_w(NUM_STAGES);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

  logic                  lock_s;
  logic [NUM_STAGES-1:0] ack_s;

`ifdef RESET_SEQUENCER_SYNC_EN
  rst_seq_sync2 #(.WIDTH(NUM_STAGES + 1)) u_sync (
    .clk   (clk),
    .rst_n (rstn_in),
    .d     ({pll_locked, stage_ack}),
    .q     ({lock_s, ack_s})
  );
`else
  assign lock_s = pll_locked;
  assign ack_s  = stage_ack;
`endif

  rst_seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rstn_stage_q, rstn_stage_d;
  logic                  seq_done_q, seq_done_d;
  logic                  seq_err_q, seq_err_d;
  logic [IDX_W-1:0]      err_stage_q, err_stage_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    rstn_stage_d = rstn_stage_q;
    seq_done_d   = seq_done_q;
    seq_err_d    = seq_err_q;
    err_stage_d  = err_stage_q;

    if (soft_rst_req) begin
      state_d      = ST_IDLE;
      rstn_stage_d = '0;
      seq_done_d   = 1'b0;
      seq_err_d    = 1'b0;
    end else if (!lock_s && (state_q inside {ST_DELAY, ST_WAIT_ACK, ST_DONE})) begin
      state_d      = ST_WAIT_LOCK;
      rstn_stage_d = '0;
      seq_done_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          rstn_stage_d = '0;
          state_d      = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (cnt_q == DLY_LAST) begin
            rstn_stage_d[idx_q] = 1'b1;
            cnt_d               = '0;
            state_d             = ST_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          // Ack is tested first so an ack landing on the timeout cycle wins.
          if (ack_s[idx_q]) begin
            if (idx_q == IDX_LAST) begin
              state_d    = ST_DONE;
              seq_done_d = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              cnt_d   = '0;
              state_d = ST_DELAY;
            end
          end else if ((ACK_TIMEOUT != 0) && (cnt_q == TMO_LAST)) begin
            state_d      = ST_ERROR;
            seq_err_d    = 1'b1;
            err_stage_d  = idx_q;
            rstn_stage_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE:  rstn_stage_d = '1;
        ST_ERROR: rstn_stage_d = '0;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      rstn_stage_q <= '0;
      seq_done_q   <= 1'b0;
      seq_err_q    <= 1'b0;
      err_stage_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      rstn_stage_q <= rstn_stage_d;
      seq_done_q   <= seq_done_d;
      seq_err_q    <= seq_err_d;
      err_stage_q  <= err_stage_d;
    end
  end

  assign rstn_stage = rstn_stage_q;
  assign seq_done   = seq_done_q;
  assign seq_err    = seq_err_q;
  assign err_stage  = err_stage_q;

endmodule
